smem_output_collector: RTL and testbench



---
 rtl/smem_pkg.sv | 26 ++
 rtl/smem_output_collector_if.sv | 29 ++
 rtl/smem_beat_fifo.sv | 48 ++++
 rtl/smem_output_collector.sv | 155 +++++++++++++++
 tb/tb_smem_output_collector.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smem_pkg.sv
// Shared constants, header field layout and FSM encoding for the SMEM result-output path.
// Pure definitions; no logic, no latency.
package smem_pkg;
  localparam int BEAT_W          = 512;
  localparam int MEM_SLOTS       = 101;

  localparam int HDR_READ_NUM_LO = 0;
  localparam int HDR_READ_NUM_HI = 9;
  localparam int HDR_MEM_SIZE_LO = 64;
  localparam int HDR_MEM_SIZE_HI = 70;
  localparam int HDR_RET_LO      = 128;
  localparam int HDR_RET_HI      = 159;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Two memory slots are packed per data beat, so a read carries ceil(mem_size/2) data beats.
  function automatic logic [7:0] data_beats(input logic [6:0] mem_size);
    return ({1'b0, mem_size} + 8'd1) >> 1;
  endfunction
endpackage

// File: rtl/smem_output_collector_if.sv
// Producer-side result handshake plus host-side line write bus.
// master = collector, slave = producer/host environment.
interface smem_output_collector_if
  import smem_pkg::*;
#(
  parameter int ADDR_W = 64
);
  logic              output_request;
  logic              output_permit;
  logic [BEAT_W-1:0] output_data;
  logic              output_valid;
  logic              output_finish;
  logic              stall;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [BEAT_W-1:0] wr_data;
  logic              wr_ready;

  modport master (
    input  output_request, output_data, output_valid, output_finish, wr_ready,
    output output_permit, stall, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output output_request, output_data, output_valid, output_finish, wr_ready,
    input  output_permit, stall, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/smem_beat_fifo.sv
// Synchronous beat FIFO with occupancy outputs; head visible the cycle after push.
// Push when full is refused unless a pop frees the slot in the same cycle.
module smem_beat_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 512,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_next
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop_ok     = pop && !empty;
  assign push_ok    = push && (!full || pop_ok);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/smem_output_collector.sv
// Collects SMEM result beats into a FIFO and writes them to host memory as consecutive 64-byte lines.
// Push-to-wr_valid 1 cycle; registered stall throttles the producer STALL_MARGIN entries before full.
module smem_output_collector
  import smem_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int STALL_MARGIN = 3,
  parameter int ADDR_W       = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8:0]             batch_size,
  input  logic [ADDR_W-1:0]      base_addr,
  smem_output_collector_if.master bus,
  output logic                   done,
  output logic                   error,
  output logic [9:0]             reads_seen,
  output logic [31:0]            beats_written
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic              permit;
  logic              stall;
  logic              expect_hdr;
  logic [7:0]        remaining;
  logic [8:0]        batch;
  logic [ADDR_W-1:0] base;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [BEAT_W-1:0] head;

  logic              start_ok;
  logic              push_drop;
  logic              hdr_bad;
  logic              drain_end;
  logic              drain_fault;
  logic [6:0]        hdr_size;
  logic [7:0]        hdr_beats;

  assign push      = bus.output_valid && permit;
  assign pop       = bus.wr_valid && bus.wr_ready;
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign push_drop = push && full && !pop;
  assign hdr_size  = bus.output_data[HDR_MEM_SIZE_HI:HDR_MEM_SIZE_LO];
  assign hdr_beats = data_beats(hdr_size);
  assign hdr_bad   = push && expect_hdr && (hdr_size >= 7'(MEM_SLOTS));

  // A pending push in DRAIN keeps count_next non-zero, so parser state is final here.
  assign drain_end   = (state == ST_DRAIN) && (count_next == '0);
  assign drain_fault = drain_end && ((reads_seen != {1'b0, batch}) || !expect_hdr);

  smem_beat_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .din        (bus.output_data),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next)
  );

  assign bus.output_permit = permit;
  assign bus.stall         = stall;
  assign bus.wr_valid      = !empty;
  assign bus.wr_data       = empty ? '0 : head;
  assign bus.wr_addr       = base + (ADDR_W'(beats_written) << 6);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      permit <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      batch  <= '0;
      base   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_ARMED;
            done  <= 1'b0;
            batch <= batch_size;
            base  <= base_addr;
          end
        end
        ST_ARMED: begin
          if (bus.output_request) begin
            state  <= ST_STREAM;
            permit <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (bus.output_finish && !bus.output_valid) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_end) begin
            state  <= ST_DONE;
            permit <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          permit <= 1'b0;
        end
      endcase

      if (start_ok)                                 error <= 1'b0;
      else if (push_drop || hdr_bad || drain_fault) error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall         <= 1'b0;
      expect_hdr    <= 1'b1;
      remaining     <= '0;
      reads_seen    <= '0;
      beats_written <= '0;
    end else begin
      stall <= (count_next >= CW'(FIFO_DEPTH - STALL_MARGIN));
      if (start_ok) begin
        expect_hdr    <= 1'b1;
        remaining     <= '0;
        reads_seen    <= '0;
        beats_written <= '0;
      end else begin
        if (pop) beats_written <= beats_written + 32'd1;
        if (push) begin
          if (expect_hdr) begin
            remaining  <= hdr_beats;
            expect_hdr <= (hdr_beats == 8'd0);
            reads_seen <= reads_seen + 10'd1;
          end else begin
            remaining  <= remaining - 8'd1;
            expect_hdr <= (remaining == 8'd1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_smem_output_collector.sv
// Directed bench for smem_output_collector: producer/host models with a line scoreboard.
module tb_smem_output_collector;
  import smem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  batch_size;
  logic [63:0] base_addr;
  logic        done;
  logic        error;
  logic [9:0]  reads_seen;
  logic [31:0] beats_written;

  always #5 clk = ~clk;

  smem_output_collector_if #(.ADDR_W(64)) ifc ();

  smem_output_collector #(
    .FIFO_DEPTH   (16),
    .STALL_MARGIN (3),
    .ADDR_W       (64)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .batch_size    (batch_size),
    .base_addr     (base_addr),
    .bus           (ifc),
    .done          (done),
    .error         (error),
    .reads_seen    (reads_seen),
    .beats_written (beats_written)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [511:0] exp_q[$];
  logic [63:0] cur_base;
  int          lines;
  int          n_pop;
  int          rdy_mode;

  function automatic logic [511:0] rnd_beat();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [511:0] hdr_beat(input int rn, input int ms);
    logic [511:0] b;
    logic [31:0]  ret;
    b   = rnd_beat();
    ret = rn * 7 + 1;
    b[HDR_READ_NUM_HI:HDR_READ_NUM_LO] = rn[9:0];
    b[HDR_MEM_SIZE_HI:HDR_MEM_SIZE_LO] = ms[6:0];
    b[HDR_RET_HI:HDR_RET_LO]           = ret;
    return b;
  endfunction

  // One clock: score the host handshake about to happen, log the pushed beat, advance to negedge.
  task automatic step();
    logic [511:0] e;
    logic [63:0]  ea;
    if (ifc.wr_valid && ifc.wr_ready) begin
      n_vec++;
      ea = cur_base + 64'(lines) * 64'd64;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write addr=%h", ifc.wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (ifc.wr_addr !== ea || ifc.wr_data !== e) begin
          n_err++;
          $display("FAIL write_line[%0d] addr=%h data=%h required addr=%h data=%h",
                   lines, ifc.wr_addr, ifc.wr_data, ea, e);
        end
      end
      lines++;
      n_pop++;
    end
    if (ifc.output_valid && ifc.output_permit) exp_q.push_back(ifc.output_data);
    @(negedge clk);
    case (rdy_mode)
      0:       ifc.wr_ready = 1'b0;
      1:       ifc.wr_ready = 1'b1;
      default: ifc.wr_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_beat(input logic [511:0] b);
    int g = 0;
    while (ifc.stall && g < 1000) begin
      step();
      g++;
    end
    if (g >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL stall_timeout stall=%b required 0", ifc.stall);
    end
    ifc.output_valid = 1'b1;
    ifc.output_data  = b;
    step();
    ifc.output_valid = 1'b0;
  endtask

  task automatic send_read(input int rn, input int ms);
    send_beat(hdr_beat(rn, ms));
    for (int i = 0; i < (ms + 1) / 2; i++) send_beat(rnd_beat());
  endtask

  task automatic start_batch(input int bs, input logic [63:0] base);
    batch_size = 9'(bs);
    base_addr  = base;
    start      = 1'b1;
    step();
    start      = 1'b0;
    batch_size = 9'd0;
    base_addr  = ~base;
    exp_q.delete();
    lines    = 0;
    cur_base = base;
    n_vec++;
    if (done !== 1'b0 || error !== 1'b0 || reads_seen !== 10'd0 || beats_written !== 32'd0) begin
      n_err++;
      $display("FAIL start_clear done=%b error=%b reads=%0d written=%0d required 0 0 0 0",
               done, error, reads_seen, beats_written);
    end
    ifc.output_finish  = 1'b0;
    ifc.output_request = 1'b1;
    step();
    n_vec++;
    if (ifc.output_permit !== 1'b1) begin
      n_err++;
      $display("FAIL permit_grant permit=%b required 1", ifc.output_permit);
    end
  endtask

  task automatic finish_batch();
    int g = 0;
    ifc.output_finish = 1'b1;
    while (done !== 1'b1 && g < 3000) begin
      step();
      g++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout done=%b required 1", done);
    end
    ifc.output_finish  = 1'b0;
    ifc.output_request = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL lines_outstanding left=%0d required 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    if ({ifc.output_permit, ifc.stall, ifc.wr_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_handshake permit/stall/wr_valid=%b required 000", tag,
               {ifc.output_permit, ifc.stall, ifc.wr_valid});
    end
    n_vec++;
    if (ifc.wr_addr !== 64'd0 || ifc.wr_data !== 512'd0) begin
      n_err++;
      $display("FAIL %s_bus wr_addr=%h wr_data_low=%h required 0", tag, ifc.wr_addr, ifc.wr_data[63:0]);
    end
    n_vec++;
    if ({done, error, reads_seen, beats_written} !== 44'd0) begin
      n_err++;
      $display("FAIL %s_status done=%b error=%b reads=%0d written=%0d required 0", tag,
               done, error, reads_seen, beats_written);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rdy_mode = 0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic();
    rdy_mode = 1;
    ifc.wr_ready = 1'b1;
    start_batch(2, 64'h0000_0000_1000_0000);
    send_beat(hdr_beat(0, 3));
    batch_size = 9'd7;
    base_addr  = 64'h0000_0000_dead_0000;
    start      = 1'b1;
    send_beat(rnd_beat());
    start      = 1'b0;
    send_beat(rnd_beat());
    send_read(1, 0);
    finish_batch();
    n_vec++;
    if (reads_seen !== 10'd2 || beats_written !== 32'd4 || error !== 1'b0 || lines != 4) begin
      n_err++;
      $display("FAIL basic_result reads=%0d written=%0d error=%b lines=%0d required 2 4 0 4",
               reads_seen, beats_written, error, lines);
    end
    n_vec++;
    if (ifc.wr_addr !== 64'h0000_0000_1000_0100) begin
      n_err++;
      $display("FAIL basic_next_addr wr_addr=%h required 0000000010000100", ifc.wr_addr);
    end
  endtask

  task automatic test_drain_done();
    int g = 0;
    rdy_mode = 0;
    ifc.wr_ready = 1'b0;
    start_batch(1, 64'h0000_0000_0000_2000);
    send_read(5, 4);
    ifc.output_finish = 1'b1;
    repeat (3) step();
    n_vec++;
    if (done !== 1'b0 || ifc.wr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL drain_hold done=%b wr_valid=%b required 0 1", done, ifc.wr_valid);
    end
    n_pop = 0;
    rdy_mode = 1;
    ifc.wr_ready = 1'b1;
    while (n_pop < 3 && g < 20) begin
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_early pops=%0d done=%b required 0", n_pop, done);
      end
      step();
      g++;
    end
    n_vec++;
    if (done !== 1'b1 || error !== 1'b0 || beats_written !== 32'd3) begin
      n_err++;
      $display("FAIL done_after_last_pop done=%b error=%b written=%0d required 1 0 3",
               done, error, beats_written);
    end
    ifc.output_finish  = 1'b0;
    ifc.output_request = 1'b0;
  endtask

  task automatic test_stall();
    logic [511:0] b [16];
    rdy_mode = 0;
    ifc.wr_ready = 1'b0;
    start_batch(1, 64'h0000_0000_0000_3000);
    b[0] = hdr_beat(2, 30);
    for (int i = 1; i < 16; i++) b[i] = rnd_beat();
    for (int i = 0; i < 13; i++) begin
      n_vec++;
      if (ifc.stall !== 1'b0) begin
        n_err++;
        $display("FAIL stall_early beats=%0d stall=%b required 0", i, ifc.stall);
      end
      ifc.output_valid = 1'b1;
      ifc.output_data  = b[i];
      step();
      ifc.output_valid = 1'b0;
    end
    n_vec++;
    if (ifc.stall !== 1'b1) begin
      n_err++;
      $display("FAIL stall_at_13 stall=%b required 1", ifc.stall);
    end
    ifc.output_valid = 1'b1;
    ifc.output_data  = b[13];
    step();
    ifc.output_valid = 1'b0;
    repeat (4) step();
    n_vec++;
    if (ifc.stall !== 1'b1 || error !== 1'b0 || beats_written !== 32'd0 || ifc.wr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stall_hold stall=%b error=%b written=%0d wr_valid=%b required 1 0 0 1",
               ifc.stall, error, beats_written, ifc.wr_valid);
    end
    rdy_mode = 1;
    ifc.wr_ready = 1'b1;
    send_beat(b[14]);
    send_beat(b[15]);
    finish_batch();
    n_vec++;
    if (beats_written !== 32'd16 || error !== 1'b0 || ifc.stall !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain written=%0d error=%b stall=%b required 16 0 0",
               beats_written, error, ifc.stall);
    end
  endtask

  task automatic test_bad_size();
    rdy_mode = 1;
    ifc.wr_ready = 1'b1;
    start_batch(1, 64'h0000_0000_0000_4000);
    send_beat(hdr_beat(3, 101));
    n_vec++;
    if (error !== 1'b1) begin
      n_err++;
      $display("FAIL bad_size_flag error=%b required 1", error);
    end
    for (int i = 0; i < 51; i++) send_beat(rnd_beat());
    finish_batch();
    n_vec++;
    if (beats_written !== 32'd52 || error !== 1'b1 || reads_seen !== 10'd1) begin
      n_err++;
      $display("FAIL bad_size_result written=%0d error=%b reads=%0d required 52 1 1",
               beats_written, error, reads_seen);
    end
  endtask

  task automatic test_short_batch();
    rdy_mode = 1;
    ifc.wr_ready = 1'b1;
    start_batch(3, 64'h0000_0000_0000_6000);
    send_read(0, 100);
    send_read(1, 1);
    n_vec++;
    if (error !== 1'b0 || reads_seen !== 10'd2) begin
      n_err++;
      $display("FAIL size100_ok error=%b reads=%0d required 0 2", error, reads_seen);
    end
    finish_batch();
    n_vec++;
    if (done !== 1'b1 || error !== 1'b1 || beats_written !== 32'd53) begin
      n_err++;
      $display("FAIL short_batch done=%b error=%b written=%0d required 1 1 53",
               done, error, beats_written);
    end
  endtask

  task automatic test_random();
    int total = 0;
    int ms;
    rdy_mode = 2;
    start_batch(64, 64'h0000_0001_8000_0000);
    for (int r = 0; r < 64; r++) begin
      ms = $urandom_range(0, 100);
      total += 1 + (ms + 1) / 2;
      send_read(r, ms);
    end
    finish_batch();
    n_vec++;
    if (beats_written !== 32'(total) || reads_seen !== 10'd64 || error !== 1'b0 || lines != total) begin
      n_err++;
      $display("FAIL random_totals written=%0d reads=%0d error=%b lines=%0d required %0d 64 0 %0d",
               beats_written, reads_seen, error, lines, total, total);
    end
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    ifc.wr_ready = 1'b0;
    start_batch(1, 64'h0000_0000_0000_5000);
    send_read(4, 8);
    n_vec++;
    if (ifc.wr_valid !== 1'b1 || reads_seen !== 10'd1) begin
      n_err++;
      $display("FAIL mid_stream wr_valid=%b reads=%0d required 1 1", ifc.wr_valid, reads_seen);
    end
    reset_n = 1'b0;
    ifc.output_request = 1'b0;
    step();
    reset_n = 1'b1;
    exp_q.delete();
    check_reset_outputs("mid_reset");
    rdy_mode = 1;
    ifc.wr_ready = 1'b1;
    start_batch(1, 64'h0000_0009_0000_0040);
    send_read(6, 2);
    finish_batch();
    n_vec++;
    if (error !== 1'b0 || beats_written !== 32'd2 || ifc.wr_addr !== 64'h0000_0009_0000_00c0) begin
      n_err++;
      $display("FAIL restart error=%b written=%0d wr_addr=%h required 0 2 00000009000000c0",
               error, beats_written, ifc.wr_addr);
    end
  endtask

  initial begin
    reset_n            = 1'b0;
    start              = 1'b0;
    batch_size         = 9'd0;
    base_addr          = 64'd0;
    ifc.output_request = 1'b0;
    ifc.output_data    = '0;
    ifc.output_valid   = 1'b0;
    ifc.output_finish  = 1'b0;
    ifc.wr_ready       = 1'b0;
    cur_base           = 64'd0;
    lines              = 0;
    n_pop              = 0;
    rdy_mode           = 0;

    test_reset();
    test_basic();
    test_drain_done();
    test_stall();
    test_bad_size();
    test_short_batch();
    test_random();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
